// File: rtl/mips_ctrl_pkg.sv
// Purpose : shared encodings for the MIPS multicycle controller (opcodes, funct codes,
//           ALU control codes, mux select codes and the FSM state enum).
// Ports   : none (package only).
package mips_ctrl_pkg;

    // Primary opcodes, instruction[31:26]
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_J     = 6'b000010;

    // R-type funct codes, instruction[5:0]
    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    // ALU control codes
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b111;

    // ALU B-operand mux selects
    localparam logic [1:0] SRCB_REGB    = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

    // PC source mux selects
    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_EXECUTE = 4'd6,
        S_ALUWB   = 4'd7,
        S_BRANCH  = 4'd8,
        S_IMMEX   = 4'd9,
        S_IMMWB   = 4'd10,
        S_JUMP    = 4'd11
    } state_t;

endpackage

// File: rtl/mips_alu_decoder.sv
// Purpose : maps {op, funct} to ALU control, extender mode and instruction legality.
// Latency : purely combinational, zero cycles.
// Backpres: none; no handshake.
// Ports   : i_op/i_funct from IR; o_alu_control, o_ext_zero, o_legal.
module mips_alu_decoder
    import mips_ctrl_pkg::*;
(
    input  logic [5:0] i_op,
    input  logic [5:0] i_funct,
    output logic [2:0] o_alu_control,
    output logic       o_ext_zero,
    output logic       o_legal
);

    always_comb begin
        o_alu_control = ALU_ADD;
        o_ext_zero    = 1'b0;
        o_legal       = 1'b0;
        case (i_op)
            OP_RTYPE: begin
                o_legal = 1'b1;
                case (i_funct)
                    FN_ADD:  o_alu_control = ALU_ADD;
                    FN_SUB:  o_alu_control = ALU_SUB;
                    FN_AND:  o_alu_control = ALU_AND;
                    FN_OR:   o_alu_control = ALU_OR;
                    FN_SLT:  o_alu_control = ALU_SLT;
                    default: o_legal       = 1'b0;
                endcase
            end
            OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_J: o_legal = 1'b1;
            OP_ADDI: begin
                o_legal       = 1'b1;
                o_alu_control = ALU_ADD;
            end
            OP_ANDI: begin
                o_legal       = 1'b1;
                o_alu_control = ALU_AND;
                o_ext_zero    = 1'b1;
            end
            OP_ORI: begin
                o_legal       = 1'b1;
                o_alu_control = ALU_OR;
                o_ext_zero    = 1'b1;
            end
            OP_SLTI: begin
                o_legal       = 1'b1;
                o_alu_control = ALU_SLT;
            end
            default: o_legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Purpose : multicycle MIPS control FSM; sequences fetch/decode/execute/mem/writeback
//           and drives every datapath select and write strobe.
// Latency : state registered; outputs combinational from state (FETCH ir_write/pc_en
//           follow i_mem_ready, BRANCH pc_en follows i_zero).
// Backpres: FETCH, MEMRD and MEMWR hold with the request asserted until i_mem_ready.
// Ports   : i_clk, i_reset (async, active-high), i_op/i_funct from IR, i_zero from ALU,
//           i_mem_ready handshake; o_* datapath controls, o_illegal_op, o_state_dbg.
module mips_multicycle_ctrl
    import mips_ctrl_pkg::*;
(
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic [5:0] i_op,
    input  logic [5:0] i_funct,
    input  logic       i_zero,
    input  logic       i_mem_ready,
    output logic       o_mem_req,
    output logic       o_mem_write,
    output logic       o_iord,
    output logic       o_ir_write,
    output logic       o_pc_en,
    output logic [1:0] o_pc_src,
    output logic       o_reg_write,
    output logic       o_reg_dst,
    output logic       o_mem_to_reg,
    output logic       o_alu_src_a,
    output logic [1:0] o_alu_src_b,
    output logic       o_ext_zero,
    output logic [2:0] o_alu_control,
    output logic       o_illegal_op,
    output logic [3:0] o_state_dbg
);

    state_t     r_state;
    state_t     w_next;
    logic [2:0] w_dec_alu;
    logic       w_dec_ext_zero;
    logic       w_dec_legal;

    // Raw strobes before the reset gate
    logic w_mem_req;
    logic w_mem_write;
    logic w_ir_write;
    logic w_pc_en;
    logic w_reg_write;
    logic w_illegal;

    mips_alu_decoder u_alu_dec (
        .i_op          (i_op),
        .i_funct       (i_funct),
        .o_alu_control (w_dec_alu),
        .o_ext_zero    (w_dec_ext_zero),
        .o_legal       (w_dec_legal)
    );

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = S_FETCH;
        case (r_state)
            S_FETCH:   w_next = i_mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                if (!w_dec_legal) begin
                    w_next = S_FETCH;
                end else begin
                    case (i_op)
                        OP_LW, OP_SW:                        w_next = S_MEMADR;
                        OP_RTYPE:                            w_next = S_EXECUTE;
                        OP_BEQ, OP_BNE:                      w_next = S_BRANCH;
                        OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI:   w_next = S_IMMEX;
                        OP_J:                                w_next = S_JUMP;
                        default:                             w_next = S_FETCH;
                    endcase
                end
            end
            S_MEMADR:  w_next = (i_op == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD:   w_next = i_mem_ready ? S_MEMWB : S_MEMRD;
            S_MEMWB:   w_next = S_FETCH;
            S_MEMWR:   w_next = i_mem_ready ? S_FETCH : S_MEMWR;
            S_EXECUTE: w_next = S_ALUWB;
            S_ALUWB:   w_next = S_FETCH;
            S_BRANCH:  w_next = S_FETCH;
            S_IMMEX:   w_next = S_IMMWB;
            S_IMMWB:   w_next = S_FETCH;
            S_JUMP:    w_next = S_FETCH;
            default:   w_next = S_FETCH;
        endcase
    end

    always_comb begin
        w_mem_req     = 1'b0;
        w_mem_write   = 1'b0;
        w_ir_write    = 1'b0;
        w_pc_en       = 1'b0;
        w_reg_write   = 1'b0;
        w_illegal     = 1'b0;
        o_iord        = 1'b0;
        o_pc_src      = PCSRC_ALU;
        o_reg_dst     = 1'b0;
        o_mem_to_reg  = 1'b0;
        o_alu_src_a   = 1'b0;
        o_alu_src_b   = SRCB_REGB;
        o_ext_zero    = 1'b0;
        o_alu_control = ALU_ADD;
        case (r_state)
            S_FETCH: begin
                w_mem_req   = 1'b1;
                o_alu_src_b = SRCB_FOUR;
                w_ir_write  = i_mem_ready;
                w_pc_en     = i_mem_ready;
            end
            S_DECODE: begin
                // ALU precomputes PC + (sext(imm) << 2) into ALUOut for a branch
                o_alu_src_b = SRCB_IMM_SH2;
                w_illegal   = ~w_dec_legal;
            end
            S_MEMADR: begin
                o_alu_src_a = 1'b1;
                o_alu_src_b = SRCB_IMM;
            end
            S_MEMRD: begin
                w_mem_req = 1'b1;
                o_iord    = 1'b1;
            end
            S_MEMWB: begin
                w_reg_write  = 1'b1;
                o_mem_to_reg = 1'b1;
            end
            S_MEMWR: begin
                w_mem_req   = 1'b1;
                w_mem_write = 1'b1;
                o_iord      = 1'b1;
            end
            S_EXECUTE: begin
                o_alu_src_a   = 1'b1;
                o_alu_control = w_dec_alu;
            end
            S_ALUWB: begin
                w_reg_write = 1'b1;
                o_reg_dst   = 1'b1;
            end
            S_BRANCH: begin
                o_alu_src_a   = 1'b1;
                o_alu_control = ALU_SUB;
                o_pc_src      = PCSRC_ALUOUT;
                w_pc_en       = (i_op == OP_BEQ) ? i_zero : ~i_zero;
            end
            S_IMMEX: begin
                o_alu_src_a   = 1'b1;
                o_alu_src_b   = SRCB_IMM;
                o_ext_zero    = w_dec_ext_zero;
                o_alu_control = w_dec_alu;
            end
            S_IMMWB: begin
                w_reg_write = 1'b1;
            end
            S_JUMP: begin
                o_pc_src = PCSRC_JUMP;
                w_pc_en  = 1'b1;
            end
            default: begin
                w_mem_req = 1'b0;
            end
        endcase
    end

    // The state register is already FETCH while reset is high, so selects come out
    // with FETCH values; only the strobes need masking so nothing fires during reset.
    assign o_mem_req    = w_mem_req   & ~i_reset;
    assign o_mem_write  = w_mem_write & ~i_reset;
    assign o_ir_write   = w_ir_write  & ~i_reset;
    assign o_pc_en      = w_pc_en     & ~i_reset;
    assign o_reg_write  = w_reg_write & ~i_reset;
    assign o_illegal_op = w_illegal   & ~i_reset;
    assign o_state_dbg  = r_state;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
module tb_mips_multicycle_ctrl;

    logic       i_clk = 1'b0;
    logic       i_reset;
    logic [5:0] i_op;
    logic [5:0] i_funct;
    logic       i_zero;
    logic       i_mem_ready;
    logic       o_mem_req, o_mem_write, o_iord, o_ir_write, o_pc_en;
    logic [1:0] o_pc_src;
    logic       o_reg_write, o_reg_dst, o_mem_to_reg, o_alu_src_a;
    logic [1:0] o_alu_src_b;
    logic       o_ext_zero;
    logic [2:0] o_alu_control;
    logic       o_illegal_op;
    logic [3:0] o_state_dbg;

    mips_multicycle_ctrl dut (
        .i_clk         (i_clk),
        .i_reset       (i_reset),
        .i_op          (i_op),
        .i_funct       (i_funct),
        .i_zero        (i_zero),
        .i_mem_ready   (i_mem_ready),
        .o_mem_req     (o_mem_req),
        .o_mem_write   (o_mem_write),
        .o_iord        (o_iord),
        .o_ir_write    (o_ir_write),
        .o_pc_en       (o_pc_en),
        .o_pc_src      (o_pc_src),
        .o_reg_write   (o_reg_write),
        .o_reg_dst     (o_reg_dst),
        .o_mem_to_reg  (o_mem_to_reg),
        .o_alu_src_a   (o_alu_src_a),
        .o_alu_src_b   (o_alu_src_b),
        .o_ext_zero    (o_ext_zero),
        .o_alu_control (o_alu_control),
        .o_illegal_op  (o_illegal_op),
        .o_state_dbg   (o_state_dbg)
    );

    always #5 i_clk = ~i_clk;

    int n_vec = 0;
    int n_err = 0;

    // Expected state trace, filled when an instruction is presented
    logic [3:0] exp_q[$];
    int fetch_wait;
    int rd_wait;
    logic       e_ill;
    logic       e_pcen;
    logic       e_ext;
    logic [2:0] e_alu;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference state trace per instruction class, including stall cycles
    task automatic push_seq(input logic [5:0] op, input logic [5:0] fn, input int fw, input int rw);
        fetch_wait = fw;
        rd_wait    = rw;
        for (int i = 0; i <= fw; i++) exp_q.push_back(4'd0);
        exp_q.push_back(4'd1);
        case (op)
            6'b100011: begin
                exp_q.push_back(4'd2);
                for (int i = 0; i <= rw; i++) exp_q.push_back(4'd3);
                exp_q.push_back(4'd4);
            end
            6'b101011: begin exp_q.push_back(4'd2); exp_q.push_back(4'd5); end
            6'b000000: begin
                if (fn == 6'b100000 || fn == 6'b100010 || fn == 6'b100100 ||
                    fn == 6'b100101 || fn == 6'b101010) begin
                    exp_q.push_back(4'd6); exp_q.push_back(4'd7);
                end
            end
            6'b000100, 6'b000101: exp_q.push_back(4'd8);
            6'b001000, 6'b001100, 6'b001101, 6'b001010: begin
                exp_q.push_back(4'd9); exp_q.push_back(4'd10);
            end
            6'b000010: exp_q.push_back(4'd11);
            default: ;
        endcase
        i_op    = op;
        i_funct = fn;
    endtask

    // Pop the trace one cycle at a time and check the DUT against it
    task automatic run_q(input string tag);
        int budget;
        logic [3:0] e;
        budget = 40;
        while (exp_q.size() > 0 && budget > 0) begin
            budget--;
            e = exp_q.pop_front();
            chk({tag, ":state"}, {28'd0, o_state_dbg}, {28'd0, e});
            i_mem_ready = 1'b1;
            if (e == 4'd0 && fetch_wait > 0) begin i_mem_ready = 1'b0; fetch_wait--; end
            if (e == 4'd3 && rd_wait > 0)    begin i_mem_ready = 1'b0; rd_wait--;    end
            #1;
            chk({tag, ":mem_req"},   {31'd0, o_mem_req},   {31'd0, (e == 4'd0 || e == 4'd3 || e == 4'd5)});
            chk({tag, ":mem_write"}, {31'd0, o_mem_write}, {31'd0, (e == 4'd5)});
            chk({tag, ":reg_write"}, {31'd0, o_reg_write}, {31'd0, (e == 4'd4 || e == 4'd7 || e == 4'd10)});
            chk({tag, ":illegal"},   {31'd0, o_illegal_op}, {31'd0, (e == 4'd1 && e_ill)});
            case (e)
                4'd0: begin
                    chk({tag, ":ir_write"}, {31'd0, o_ir_write}, {31'd0, i_mem_ready});
                    chk({tag, ":fetch_pc_en"}, {31'd0, o_pc_en}, {31'd0, i_mem_ready});
                    chk({tag, ":fetch_srcb"}, {30'd0, o_alu_src_b}, 32'd1);
                end
                4'd3: chk({tag, ":rd_iord"}, {31'd0, o_iord}, 32'd1);
                4'd4: begin
                    chk({tag, ":mem_to_reg"}, {31'd0, o_mem_to_reg}, 32'd1);
                    chk({tag, ":wb_reg_dst"}, {31'd0, o_reg_dst}, 32'd0);
                end
                4'd6: chk({tag, ":ex_alu"}, {29'd0, o_alu_control}, {29'd0, e_alu});
                4'd7: chk({tag, ":reg_dst"}, {31'd0, o_reg_dst}, 32'd1);
                4'd8: begin
                    chk({tag, ":br_pc_en"}, {31'd0, o_pc_en}, {31'd0, e_pcen});
                    chk({tag, ":br_pc_src"}, {30'd0, o_pc_src}, 32'd1);
                    chk({tag, ":br_alu"}, {29'd0, o_alu_control}, 32'd6);
                end
                4'd9: begin
                    chk({tag, ":imm_ext"}, {31'd0, o_ext_zero}, {31'd0, e_ext});
                    chk({tag, ":imm_srcb"}, {30'd0, o_alu_src_b}, 32'd2);
                    chk({tag, ":imm_alu"}, {29'd0, o_alu_control}, {29'd0, e_alu});
                end
                4'd11: begin
                    chk({tag, ":j_pc_en"}, {31'd0, o_pc_en}, 32'd1);
                    chk({tag, ":j_pc_src"}, {30'd0, o_pc_src}, 32'd2);
                end
                default: ;
            endcase
            @(posedge i_clk); #2;
        end
        if (budget == 0) chk({tag, ":budget"}, 32'd0, 32'd1);
    endtask

    initial begin
        i_reset = 1'b1; i_op = 6'd0; i_funct = 6'd0; i_zero = 1'b0; i_mem_ready = 1'b1;
        e_ill = 1'b0; e_pcen = 1'b0; e_ext = 1'b0; e_alu = 3'b010;
        fetch_wait = 0; rd_wait = 0;
        @(posedge i_clk); #2;
        // Reset state: FETCH selects, all strobes low even with mem_ready high
        chk("rst:state", {28'd0, o_state_dbg}, 32'd0);
        chk("rst:mem_req", {31'd0, o_mem_req}, 32'd0);
        chk("rst:ir_write", {31'd0, o_ir_write}, 32'd0);
        chk("rst:pc_en", {31'd0, o_pc_en}, 32'd0);
        chk("rst:srcb", {30'd0, o_alu_src_b}, 32'd1);
        i_reset = 1'b0;
        #1;

        e_alu = 3'b010; push_seq(6'b000000, 6'b100000, 1, 0); run_q("r_add");
        e_alu = 3'b110; push_seq(6'b000000, 6'b100010, 0, 0); run_q("r_sub");
        e_alu = 3'b111; push_seq(6'b000000, 6'b101010, 0, 0); run_q("r_slt");
        push_seq(6'b100011, 6'd0, 0, 2); run_q("lw_wait");
        push_seq(6'b101011, 6'd0, 0, 0); run_q("sw");

        i_zero = 1'b1; e_pcen = 1'b1; push_seq(6'b000100, 6'd0, 0, 0); run_q("beq_z1");
        i_zero = 1'b0; e_pcen = 1'b0; push_seq(6'b000100, 6'd0, 0, 0); run_q("beq_z0");
        i_zero = 1'b0; e_pcen = 1'b1; push_seq(6'b000101, 6'd0, 0, 0); run_q("bne_z0");
        i_zero = 1'b1; e_pcen = 1'b0; push_seq(6'b000101, 6'd0, 0, 0); run_q("bne_z1");

        e_ext = 1'b1; e_alu = 3'b001; push_seq(6'b001101, 6'd0, 0, 0); run_q("ori");
        e_ext = 1'b0; e_alu = 3'b010; push_seq(6'b001000, 6'd0, 0, 0); run_q("addi");
        e_ext = 1'b1; e_alu = 3'b000; push_seq(6'b001100, 6'd0, 0, 0); run_q("andi");
        e_ext = 1'b0; e_alu = 3'b111; push_seq(6'b001010, 6'd0, 0, 0); run_q("slti");
        push_seq(6'b000010, 6'd0, 0, 0); run_q("j");

        e_ill = 1'b1; push_seq(6'b111111, 6'd0, 0, 0);     run_q("ill_op");
        e_ill = 1'b1; push_seq(6'b000000, 6'b000011, 0, 0); run_q("ill_fn");
        e_ill = 1'b0;

        // Reset in the middle of a stalled store
        push_seq(6'b101011, 6'd0, 0, 0);
        void'(exp_q.pop_back());
        run_q("sw_pre");
        chk("mw:state", {28'd0, o_state_dbg}, 32'd5);
        i_mem_ready = 1'b0;
        @(posedge i_clk); #2;
        chk("mw:hold_state", {28'd0, o_state_dbg}, 32'd5);
        chk("mw:hold_wr", {31'd0, o_mem_write}, 32'd1);
        chk("mw:hold_iord", {31'd0, o_iord}, 32'd1);
        i_reset = 1'b1;
        #1;
        chk("mw:rst_state", {28'd0, o_state_dbg}, 32'd0);
        chk("mw:rst_wr", {31'd0, o_mem_write}, 32'd0);
        chk("mw:rst_req", {31'd0, o_mem_req}, 32'd0);
        @(posedge i_clk); #2;
        chk("mw:rst_hold_req", {31'd0, o_mem_req}, 32'd0);
        i_reset = 1'b0;
        #1;
        // Fetch restarts after release; run the store again to completion
        push_seq(6'b101011, 6'd0, 0, 0); run_q("sw_after_rst");
        chk("end:state", {28'd0, o_state_dbg}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/mips_multicycle_ctrl.md
# mips_multicycle_ctrl

Multicycle control FSM for the MIPS datapath. It sequences fetch, decode, execute, memory access and writeback for each instruction, and drives every datapath select and write strobe, including the immediate extender mode (sign or zero) and the ALU B-operand mux. It sits beside the datapath, taking opcode/funct from the instruction register and `zero` from the ALU. It stalls on a single memory ready handshake.

## Interface
- No parameters; opcode, funct and ALU encodings are fixed constants in the package.
- `clk`  in  1  rising-edge clock
- `reset`  in  1  asynchronous, active-high; forces state FETCH
- `op`  in  6  instruction[31:26] from IR
- `funct`  in  6  instruction[5:0] from IR
- `zero`  in  1  ALU result == 0
- `mem_ready`  in  1  memory completes access this cycle
- `mem_req`  out  1  memory access request
- `mem_write`  out  1  store strobe (valid with mem_req)
- `iord`  out  1  0 = PC addresses memory, 1 = ALUOut
- `ir_write`  out  1  load IR
- `pc_en`  out  1  PC load enable
- `pc_src`  out  2  00 ALU, 01 ALUOut, 10 jump target
- `reg_write`  out  1  register file write
- `reg_dst`  out  1  0 = rt, 1 = rd
- `mem_to_reg`  out  1  0 = ALUOut, 1 = MDR
- `alu_src_a`  out  1  0 = PC, 1 = reg A
- `alu_src_b`  out  2  00 reg B, 01 const 4, 10 ext imm, 11 ext imm<<2
- `ext_zero`  out  1  extender mode: 1 = zero-extend, 0 = sign-extend
- `alu_control`  out  3  010 add, 110 sub, 000 and, 001 or, 111 slt
- `illegal_op`  out  1  one-cycle pulse on unsupported op/funct
- `state_dbg`  out  4  current state encoding

## Operation
- Supported opcodes: R 000000, lw 100011, sw 101011, beq 000100, bne 000101, addi 001000, andi 001100, ori 001101, slti 001010, j 000010.
- Supported R funct codes: add 100000, sub 100010, and 100100, or 100101, slt 101010.
- States (4-bit encoding): FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, EXECUTE 6, ALUWB 7, BRANCH 8, IMMEX 9, IMMWB 10, JUMP 11.
- FETCH: mem_req=1, iord=0, alu_src_a=0, alu_src_b=01, add, pc_src=00.
  - If mem_ready: ir_write=1, pc_en=1, go to DECODE.
  - Otherwise hold FETCH with ir_write=0 and pc_en=0.
- DECODE: alu_src_a=0, alu_src_b=11, ext_zero=0, add (branch target into ALUOut). Next state:
  - lw/sw → MEMADR
  - R → EXECUTE
  - beq/bne → BRANCH
  - addi/andi/ori/slti → IMMEX
  - j → JUMP
  - Otherwise: illegal_op=1, go to FETCH. An unsupported funct with op=R is also illegal.
- MEMADR: alu_src_a=1, alu_src_b=10, ext_zero=0, add. Go to MEMRD (lw) or MEMWR (sw).
- MEMRD: mem_req=1, iord=1. Hold until mem_ready, then go to MEMWB.
- MEMWB: reg_write=1, reg_dst=0, mem_to_reg=1. Go to FETCH.
- MEMWR: mem_req=1, mem_write=1, iord=1. Hold until mem_ready, then go to FETCH.
- EXECUTE: alu_src_a=1, alu_src_b=00, alu_control from funct. Go to ALUWB.
- ALUWB: reg_write=1, reg_dst=1, mem_to_reg=0. Go to FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, sub, pc_src=01.
  - pc_en = zero for beq; pc_en = ~zero for bne.
  - Go to FETCH.
- IMMEX: alu_src_a=1, alu_src_b=10. Go to IMMWB.
  - ext_zero=1 for andi/ori, 0 for addi/slti.
  - alu_control: addi add, andi and, ori or, slti slt.
- IMMWB: reg_write=1, reg_dst=0, mem_to_reg=0. Go to FETCH.
- JUMP: pc_src=10, pc_en=1. Go to FETCH.
- Unlisted outputs default to 0 in every state. alu_control defaults to 010.

## Timing
- State is registered. Outputs are combinational from state, except:
  - ir_write and pc_en in FETCH depend on mem_ready.
  - pc_en in BRANCH depends on zero.
- Cycle counts with mem_ready tied high: lw 5, sw 4, R 4, addi/andi/ori/slti 4, beq/bne 3, j 3. Each wait cycle adds 1.
- Handshake:
  - mem_req stays high and iord/mem_write stay stable until the cycle in which mem_ready=1.
  - Exactly one access completes per mem_ready=1 cycle.
  - mem_ready is ignored outside FETCH/MEMRD/MEMWR.
- Reset:
  - Asynchronous assert: state=FETCH immediately, including mid-instruction or mid-wait.
  - While reset=1, all strobes are forced to 0: mem_req, mem_write, ir_write, pc_en, reg_write, illegal_op. Selects take FETCH values; state_dbg=0.
  - First fetch request in the cycle after deassertion.
- illegal_op is exactly one cycle; it never coincides with a write strobe.

## Structure
- Package `mips_ctrl_pkg` holds:
  - opcode and funct localparams
  - ALU control codes
  - alu_src_b and pc_src codes
  - state enum typedef
- Sub-module `mips_alu_decoder` maps {op, funct} to {alu_control, ext_zero, legal}. It is combinational and reused for IMMEX/EXECUTE and the DECODE legality check.
- The FSM next-state logic and output decode live in the top module.

## Test plan
- R-type add (op=000000, funct=100000), mem_ready=1:
  - State sequence 0,1,6,7,0.
  - In state 7: reg_write=1, reg_dst=1.
- lw with mem_ready low for 2 cycles in MEMRD:
  - State holds 3 for those cycles with mem_req=1, iord=1.
  - Total 7 cycles; MEMWB asserts mem_to_reg=1.
- beq with zero=1, then zero=0:
  - BRANCH gives pc_en=1 then 0.
  - bne with zero=0 gives pc_en=1; pc_src=01 in both cases.
- ori in IMMEX: ext_zero=1, alu_src_b=10, alu_control=001.
- addi in IMMEX: ext_zero=0, alu_control=010.
- Decode op=111111:
  - illegal_op pulses 1 cycle, next state 0, no reg_write or mem_write.
  - Same for R funct=000011.
- Reset asserted mid-MEMWR wait: state_dbg is 0 in the same cycle, mem_write drops immediately, fetch resumes one cycle after release.
